// File: rtl/exe_sequencer.sv
// Issue/occupancy controller ahead of Execute: holds one bundle for in_lat extra
// cycles (out_valid in_lat+1 cycles after accept); stalls Decode while occupied.
module exe_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int LAT_W      = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-3:0] in_addr,
  input  logic [31:0]           in_insn,
  input  logic [LAT_W-1:0]      in_lat,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-3:0] out_addr,
  output logic [31:0]           out_insn,
  output logic                  busy,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      retire_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e                  state_q, state_d;
  logic [LAT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-3:0]   addr_q, addr_d;
  logic [31:0]             insn_q, insn_d;
  logic                    out_valid_q, out_valid_d;
  logic                    busy_q, busy_d;
  logic [CNT_W-1:0]        stall_q, stall_d;
  logic [CNT_W-1:0]        retire_q, retire_d;

  logic accept;
  logic handoff;

  // DONE can take a new op in the same cycle it hands off, giving 1/cycle for lat-0 ops.
  assign in_ready = !flush && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept   = in_valid && in_ready;
  assign handoff  = out_valid_q && out_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    insn_d   = insn_q;
    stall_d  = stall_q;
    retire_d = retire_q;

    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            addr_d = in_addr;
            insn_d = in_insn;
            if (in_lat == '0) begin
              state_d = DONE;
            end else begin
              state_d = EXEC;
              cnt_d   = in_lat;
            end
          end else if ((state_q == DONE) && out_ready) begin
            state_d = IDLE;
          end
        end
        EXEC: begin
          cnt_d = cnt_q - LAT_ONE;
          if (cnt_q == LAT_ONE) begin
            state_d = DONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    if (in_valid && !in_ready && !flush && (stall_q != '1)) begin
      stall_d = stall_q + CNT_ONE;
    end

    // A handoff in a flush cycle has already completed, so it still retires.
    if (handoff) begin
      retire_d = retire_q + CNT_ONE;
    end

    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      insn_q      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      stall_q     <= '0;
      retire_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      insn_q      <= insn_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      stall_q     <= stall_d;
      retire_q    <= retire_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_addr   = addr_q;
  assign out_insn   = insn_q;
  assign busy       = busy_q;
  assign stall_cnt  = stall_q;
  assign retire_cnt = retire_q;

endmodule

// File: tb/tb_exe_sequencer.sv
// Bench for exe_sequencer with CNT_W=4 / LAT_W=4: directed scenarios plus random traffic vs an occupancy model.
module tb_exe_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [29:0] in_addr;
  logic [31:0] in_insn;
  logic [3:0]  in_lat;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [29:0] out_addr;
  logic [31:0] out_insn;
  logic        busy;
  logic [3:0]  stall_cnt;
  logic [3:0]  retire_cnt;

  int total = 0;
  int bad   = 0;

  exe_sequencer #(.ADDR_WIDTH(32), .LAT_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_insn(in_insn),
    .in_lat(in_lat), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_insn(out_insn),
    .busy(busy), .stall_cnt(stall_cnt), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  // Occupancy model: an op is held until the cycle index at which it becomes complete.
  int          cyc_n = 0;
  bit          m_has;
  int          m_done;
  logic [29:0] m_addr;
  logic [31:0] m_insn;
  int          m_stall;
  int          m_retire;
  bit          e_in_ready;
  bit          e_out_valid;

  function automatic void model_reset();
    m_has = 0; m_done = 0; m_addr = '0; m_insn = '0; m_stall = 0; m_retire = 0;
  endfunction

  function automatic void model_sample();
    e_out_valid = m_has && (cyc_n >= m_done);
    e_in_ready  = !flush && (!m_has || (e_out_valid && out_ready));
  endfunction

  function automatic void model_edge();
    if (!rst) begin
      model_reset();
    end else begin
      if (e_out_valid && out_ready) m_retire = (m_retire + 1) % 16;
      if (in_valid && !e_in_ready && !flush && m_stall < 15) m_stall++;
      if (flush) begin
        m_has = 0;
      end else begin
        if (e_out_valid && out_ready) m_has = 0;
        if (in_valid && e_in_ready) begin
          m_has  = 1;
          m_done = cyc_n + int'(in_lat) + 1;
          m_addr = in_addr;
          m_insn = in_insn;
        end
      end
    end
    cyc_n++;
  endfunction

  task automatic drive(input logic v, input logic [3:0] lat, input logic [29:0] a,
                       input logic [31:0] ins, input logic ordy, input logic fl);
    in_valid = v; in_lat = lat; in_addr = a; in_insn = ins; out_ready = ordy; flush = fl;
  endtask

  task automatic settle();
    #1;
    model_sample();
  endtask

  task automatic adv();
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(1'b0, 4'd0, 30'd0, 32'd0, 1'b0, 1'b0);
    settle();
    adv();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b1, 4'd0, 30'h3C, 32'hDEAD_0001, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      settle();
      if (k == 1) begin
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_hold out_valid got=%b exp=0", out_valid); end
      end
      adv();
    end
    rst = 1'b1;
    settle();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid got=%b exp=0", out_valid); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset busy got=%b exp=0", busy); end
    total++;
    if (stall_cnt !== 4'd0 || retire_cnt !== 4'd0) begin
      bad++; $display("FAIL reset counters got stall=%0d retire=%0d exp=0/0", stall_cnt, retire_cnt);
    end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset first_accept in_ready got=%b exp=1", in_ready); end
    adv();
    drive(1'b0, 4'd0, 30'd0, 32'd0, 1'b1, 1'b0);
    settle();
    total++;
    if (out_valid !== 1'b1 || out_addr !== 30'h3C) begin
      bad++; $display("FAIL reset first_op got valid=%b addr=%h exp=1/03c", out_valid, out_addr);
    end
    adv();
  endtask

  task automatic test_stream();
    do_reset();
    for (int c = 0; c <= 9; c++) begin
      if (c < 8) drive(1'b1, 4'd0, 30'h100 + 30'(c), 32'h1000 + 32'(c), 1'b1, 1'b0);
      else       drive(1'b0, 4'd0, 30'd0, 32'd0, 1'b1, 1'b0);
      settle();
      if (c >= 1 && c <= 8) begin
        total++;
        if (out_valid !== 1'b1 || out_addr !== 30'h100 + 30'(c - 1)) begin
          bad++; $display("FAIL stream c=%0d got valid=%b addr=%h exp=1/%h", c, out_valid, out_addr, 30'h100 + 30'(c - 1));
        end
      end
      if (c == 9) begin
        total++;
        if (retire_cnt !== 4'd8 || stall_cnt !== 4'd0) begin
          bad++; $display("FAIL stream counters got retire=%0d stall=%0d exp=8/0", retire_cnt, stall_cnt);
        end
      end
      adv();
    end
  endtask

  task automatic test_multicycle();
    do_reset();
    drive(1'b1, 4'd3, 30'h40, 32'h02A00093, 1'b1, 1'b0);
    settle();
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL multi accept in_ready got=%b exp=1", in_ready); end
    adv();
    drive(1'b1, 4'd0, 30'h44, 32'h0000_0013, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      settle();
      total++;
      if (in_ready !== (k == 4)) begin bad++; $display("FAIL multi k=%0d in_ready got=%b exp=%b", k, in_ready, k == 4); end
      total++;
      if (out_valid !== (k == 4)) begin bad++; $display("FAIL multi k=%0d out_valid got=%b exp=%b", k, out_valid, k == 4); end
      if (k == 4) begin
        total++;
        if (out_insn !== 32'h02A00093) begin bad++; $display("FAIL multi insn got=%h exp=02a00093", out_insn); end
      end
      adv();
    end
    drive(1'b0, 4'd0, 30'd0, 32'd0, 1'b1, 1'b0);
    settle();
    total++;
    if (stall_cnt !== 4'd3) begin bad++; $display("FAIL multi stall_cnt got=%0d exp=3", stall_cnt); end
    adv();
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(1'b1, 4'd0, 30'h55, 32'hAAAA_5555, 1'b0, 1'b0);
    settle();
    adv();
    drive(1'b1, 4'd0, 30'h66, 32'h6666_0000, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      settle();
      total++;
      if (out_valid !== 1'b1 || out_addr !== 30'h55 || out_insn !== 32'hAAAA_5555 || in_ready !== 1'b0) begin
        bad++; $display("FAIL bp k=%0d got valid=%b addr=%h insn=%h rdy=%b exp=1/055/aaaa5555/0",
                        k, out_valid, out_addr, out_insn, in_ready);
      end
      adv();
    end
    out_ready = 1'b1;
    settle();
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL bp release in_ready got=%b exp=1", in_ready); end
    adv();
    drive(1'b0, 4'd0, 30'd0, 32'd0, 1'b0, 1'b0);
    settle();
    total++;
    if (stall_cnt !== 4'd5 || retire_cnt !== 4'd1 || out_valid !== 1'b1 || out_addr !== 30'h66) begin
      bad++; $display("FAIL bp after got stall=%0d retire=%0d valid=%b addr=%h exp=5/1/1/066",
                      stall_cnt, retire_cnt, out_valid, out_addr);
    end
    adv();
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b1, 4'd10, 30'h80, 32'h8080_8080, 1'b1, 1'b0);
    settle();
    adv();
    drive(1'b1, 4'd0, 30'h88, 32'h8888_0000, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) flush = 1'b1;
      settle();
      if (k == 4) begin
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL flush in_ready got=%b exp=0", in_ready); end
      end
      adv();
    end
    drive(1'b1, 4'd0, 30'h90, 32'h9090_0000, 1'b1, 1'b0);
    settle();
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL flush after got valid=%b busy=%b rdy=%b exp=0/0/1", out_valid, busy, in_ready);
    end
    total++;
    if (retire_cnt !== 4'd0) begin bad++; $display("FAIL flush retire got=%0d exp=0", retire_cnt); end
    adv();
    drive(1'b0, 4'd0, 30'd0, 32'd0, 1'b1, 1'b0);
    settle();
    total++;
    if (out_valid !== 1'b1 || out_addr !== 30'h90) begin
      bad++; $display("FAIL flush next_op got valid=%b addr=%h exp=1/090", out_valid, out_addr);
    end
    adv();
  endtask

  task automatic test_counter_limits();
    do_reset();
    for (int k = 0; k <= 38; k++) begin
      if (k == 0)       drive(1'b1, 4'd15, 30'h200, 32'h0000_ABCD, 1'b0, 1'b0);
      else if (k <= 20) drive(1'b1, 4'd0, 30'h300, 32'h1, 1'b0, 1'b0);
      else if (k <= 36) drive(1'b1, 4'd0, 30'h300 + 30'(k), 32'(k), 1'b1, 1'b0);
      else              drive(1'b0, 4'd0, 30'd0, 32'd0, 1'b1, 1'b0);
      settle();
      if (k == 15 || k == 16) begin
        total++;
        if (out_valid !== (k == 16)) begin bad++; $display("FAIL maxlat k=%0d out_valid got=%b exp=%b", k, out_valid, k == 16); end
      end
      if (k == 21) begin
        total++;
        if (stall_cnt !== 4'd15) begin bad++; $display("FAIL stall_sat got=%0d exp=15", stall_cnt); end
      end
      if (k == 38) begin
        total++;
        if (retire_cnt !== 4'd1 || stall_cnt !== 4'd15) begin
          bad++; $display("FAIL retire_wrap got retire=%0d stall=%0d exp=1/15", retire_cnt, stall_cnt);
        end
      end
      adv();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      drive($urandom_range(0, 3) != 0,
            ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3)),
            30'($urandom), 32'($urandom),
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0);
      settle();
      total++;
      if (in_ready !== e_in_ready) begin bad++; $display("FAIL rnd k=%0d in_ready got=%b exp=%b", k, in_ready, e_in_ready); end
      total++;
      if (out_valid !== e_out_valid) begin bad++; $display("FAIL rnd k=%0d out_valid got=%b exp=%b", k, out_valid, e_out_valid); end
      total++;
      if (busy !== m_has) begin bad++; $display("FAIL rnd k=%0d busy got=%b exp=%b", k, busy, m_has); end
      total++;
      if (stall_cnt !== 4'(m_stall) || retire_cnt !== 4'(m_retire)) begin
        bad++; $display("FAIL rnd k=%0d counters got stall=%0d retire=%0d exp=%0d/%0d", k, stall_cnt, retire_cnt, m_stall, m_retire);
      end
      if (e_out_valid) begin
        total++;
        if (out_addr !== m_addr || out_insn !== m_insn) begin
          bad++; $display("FAIL rnd k=%0d data got=%h/%h exp=%h/%h", k, out_addr, out_insn, m_addr, m_insn);
        end
      end
      adv();
    end
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 4'd0, 30'd0, 32'd0, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    test_reset();
    test_stream();
    test_multicycle();
    test_backpressure();
    test_flush();
    test_counter_limits();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
